ha_collector: RTL and testbench

HA_COLLECTOR -- requirements
Module: ha_collector

---
 rtl/ha_pkg.sv | 11 +
 rtl/ha_collector.sv | 148 ++++++++++++++
 tb/tb_ha_collector.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ha_pkg.sv
// Shared types and constants for the half-adder result collector.
package ha_pkg;

  localparam int HA_WIDTH = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } col_state_e;

endpackage

// File: rtl/ha_collector.sv
// Packs a stream of half-adder sum/carry pairs LSB-first into words, with a
// carry popcount, partial-word flush and a one-deep output register.
module ha_collector
  import ha_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sum,
  input  logic             in_carry,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_carry,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_short
);

  col_state_e       state_q, state_d;
  logic [WIDTH-1:0] sum_buf_q, sum_buf_d;
  logic [WIDTH-1:0] carry_buf_q, carry_buf_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_buf_q, short_buf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [WIDTH-1:0] out_carry_q, out_carry_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_short_q, out_short_d;

  logic             accept;
  logic             out_free;
  logic             complete;
  logic             emit;
  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] sum_nx, carry_nx;
  logic [CNT_W-1:0] idx_nx, cnt_nx;

  // Ready depends only on state and reset, never on in_valid.
  assign in_ready  = (state_q == COLLECT) && !rst;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_cnt   = out_cnt_q;
  assign out_short = out_short_q;

  always_comb begin
    state_d     = state_q;
    sum_buf_d   = sum_buf_q;
    carry_buf_d = carry_buf_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    short_buf_d = short_buf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_cnt_d   = out_cnt_q;
    out_short_d = out_short_q;

    accept   = in_valid && in_ready;
    out_free = !out_valid_q || out_ready;
    bit_sel  = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;
    sum_nx   = (accept && in_sum)   ? (sum_buf_q | bit_sel)   : sum_buf_q;
    carry_nx = (accept && in_carry) ? (carry_buf_q | bit_sel) : carry_buf_q;
    idx_nx   = idx_q + CNT_W'(accept);
    cnt_nx   = cnt_q + CNT_W'(accept && in_carry);
    complete = accept && (idx_q == CNT_W'(WIDTH - 1));
    emit     = complete || (flush && ((idx_q != '0) || accept));

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      COLLECT: begin
        sum_buf_d   = sum_nx;
        carry_buf_d = carry_nx;
        idx_d       = idx_nx;
        cnt_d       = cnt_nx;
        if (emit) begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_sum_d   = sum_nx;
            out_carry_d = carry_nx;
            out_cnt_d   = cnt_nx;
            out_short_d = !complete;
            sum_buf_d   = '0;
            carry_buf_d = '0;
            idx_d       = '0;
            cnt_d       = '0;
          end else begin
            // Output still occupied: park the finished word until it drains.
            state_d     = FULL;
            short_buf_d = !complete;
          end
        end
      end
      FULL: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b1;
          out_sum_d   = sum_buf_q;
          out_carry_d = carry_buf_q;
          out_cnt_d   = cnt_q;
          out_short_d = short_buf_q;
          sum_buf_d   = '0;
          carry_buf_d = '0;
          idx_d       = '0;
          cnt_d       = '0;
          short_buf_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      sum_buf_q   <= '0;
      carry_buf_q <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      short_buf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= '0;
      out_cnt_q   <= '0;
      out_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_buf_q   <= sum_buf_d;
      carry_buf_q <= carry_buf_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      short_buf_q <= short_buf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_cnt_q   <= out_cnt_d;
      out_short_q <= out_short_d;
    end
  end

endmodule

// File: tb/tb_ha_collector.sv
// Randomized scoreboard bench for ha_collector with directed corner cases.
module tb_ha_collector;
  import ha_pkg::*;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sum = 1'b0;
  logic          in_carry = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic [W-1:0]  out_carry;
  logic [CW-1:0] out_cnt;
  logic          out_short;

  always #5 clk = ~clk;

  ha_collector #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_cnt(out_cnt), .out_short(out_short)
  );

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    int           cnt;
    logic         sh;
  } word_t;

  word_t exp_q[$];
  int    pend_s[$];
  int    pend_c[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    words_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word is simply the list of accepted pairs, bit i = pair i.
  function automatic word_t build_word();
    word_t w;
    w.s = '0;
    w.c = '0;
    w.cnt = 0;
    for (int i = 0; i < pend_s.size(); i++) begin
      w.s   = w.s + (W'(pend_s[i]) << i);
      w.c   = w.c + (W'(pend_c[i]) << i);
      w.cnt = w.cnt + pend_c[i];
    end
    w.sh = (pend_s.size() < W);
    return w;
  endfunction

  // Model: evaluates what the coming rising edge will do with the current inputs.
  always @(negedge clk) begin
    if (rst) begin
      pend_s.delete();
      pend_c.delete();
      exp_q.delete();
    end else if (in_ready) begin
      if (in_valid) begin
        pend_s.push_back(int'(in_sum));
        pend_c.push_back(int'(in_carry));
      end
      if (pend_s.size() == W || (flush && pend_s.size() > 0)) begin
        exp_q.push_back(build_word());
        pend_s.delete();
        pend_c.delete();
      end
    end
  end

  // Monitor: compares each consumed word and checks hold stability.
  logic          hold_prev = 1'b0;
  logic [W-1:0]  prev_s, prev_c;
  logic [CW-1:0] prev_cnt;
  logic          prev_sh;

  always @(negedge clk) begin
    word_t e;
    if (rst || !out_valid) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_sum", 64'(out_sum), 64'(prev_s));
        chk("hold_carry", 64'(out_carry), 64'(prev_c));
        chk("hold_cnt", 64'(out_cnt), 64'(prev_cnt));
        chk("hold_short", 64'(out_short), 64'(prev_sh));
      end
      if (out_ready) begin
        hold_prev = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(out_sum), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sum", 64'(out_sum), 64'(e.s));
          chk("sb_carry", 64'(out_carry), 64'(e.c));
          chk("sb_cnt", 64'(out_cnt), 64'(e.cnt));
          chk("sb_short", 64'(out_short), 64'(e.sh));
          words_seen++;
        end
      end else begin
        hold_prev = 1'b1;
        prev_s    = out_sum;
        prev_c    = out_carry;
        prev_cnt  = out_cnt;
        prev_sh   = out_short;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic c);
    logic acc;
    int   k;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    acc = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] s, input logic [W-1:0] c,
                           input int cnt, input logic sh);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(out_sum), 64'(s));
    chk({tag, "_carry"}, 64'(out_carry), 64'(c));
    chk({tag, "_cnt"}, 64'(out_cnt), 64'(cnt));
    chk({tag, "_short"}, 64'(out_short), 64'(sh));
  endtask

  initial begin
    int base;
    int lows;
    int pulses;
    int k;

    // Reset state.
    cyc();
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_cnt", 64'(out_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // Alternating pairs, full word, one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < W; i++) send(i % 2 == 0, i % 2 == 1);
    check_out("alt", 8'h55, 8'hAA, 4, 1'b0);
    cyc();

    // Backpressure: two full words with the output blocked.
    out_ready = 1'b0;
    base = words_seen;
    for (int i = 0; i < 2 * W; i++) send(1'b1, 1'b1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    check_out("bp_first", 8'hFF, 8'hFF, 8, 1'b0);
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("bp_words", 64'(words_seen - base), 64'd2);
    chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);

    // Partial word via flush.
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_out("flush", 8'h03, 8'h06, 2, 1'b1);
    cyc();

    // Reset mid-word discards it.
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    cyc();
    chk("midrst_valid2", 64'(out_valid), 64'd0);
    for (int i = 0; i < W; i++) send(1'b0, 1'b0);
    check_out("zero", 8'h00, 8'h00, 0, 1'b0);
    cyc();

    // Streaming: 64 back-to-back pairs.
    lows = 0;
    pulses = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_sum   = 1'($urandom);
      in_carry = 1'($urandom);
      @(negedge clk);
      if (!in_ready) lows++;
      if (out_valid) pulses++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) pulses++;
    cyc();
    chk("stream_ready_lows", 64'(lows), 64'd0);
    chk("stream_pulses", 64'(pulses), 64'd8);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_sum    = 1'($urandom);
      in_carry  = 1'($urandom);
      flush     = ($urandom % 8) == 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 97) == 0;
      cyc();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (k = 0; k < 50; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      cyc();
    end
    chk("drain_done", 64'(exp_q.size() == 0 && !out_valid), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
